spi_frontend: RTL and testbench

//  SPI-slave front end between the external host (SPI master) and the FPGA's

---
 rtl/spi_frontend.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_frontend.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : spi_frontend
//  Description : SPI-slave (mode 0) front end bridging an external SPI host
//                to the 32-bit internal streaming fabric. The SPI pins are
//                oversampled in the clk domain.
//                  - host->FPGA words (frame=1) are pushed through a 2-entry
//                    skid FIFO onto the h2f AXI-Stream master.
//                  - control words (frame=0) carry an opcode in the top byte;
//                    opcode 8'h01 clears the sticky error flags.
//                  - each outgoing MISO word is either an f2h stream word or
//                    a status word, picked at word start.
//                  - spi_int tells the host when it should poll.
//  Ports       : clk, rst                 - system clock, sync active-high reset
//                spi_clk/cs/mosi/frame    - async SPI inputs from the host
//                spi_miso                 - serial data back to the host
//                h2f_*                    - host->FPGA stream (master)
//                f2h_*                    - FPGA->host stream (slave)
//                fpga2host_fifo_filled    - words pending toward host
//                host2fpga_fifo_empty     - free slots toward FPGA
//                err_outfifo_overflow_pulse - output FIFO overflow strobe
//                spi_int                  - attention request to the host
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_frontend #(
    parameter int WORD_W  = 32,     // SPI word / stream width (>= 24)
    parameter int SYNC_FF = 2       // synchroniser depth (>= 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    input  logic              spi_frame,
    output logic              spi_miso,
    output logic [WORD_W-1:0] h2f_tdata,
    output logic              h2f_tvalid,
    input  logic              h2f_tready,
    input  logic [WORD_W-1:0] f2h_tdata,
    input  logic              f2h_tvalid,
    output logic              f2h_tready,
    input  logic [9:0]        fpga2host_fifo_filled,
    input  logic [9:0]        host2fpga_fifo_empty,
    input  logic              err_outfifo_overflow_pulse,
    output logic              spi_int
);

    localparam int                 c_CNT_W    = $clog2(WORD_W);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WORD_W - 1);
    localparam logic [7:0]         c_OP_CLR   = 8'h01;

    // ------------------------------------------------------------------
    // Synchronisers. The cs chain resets to 0 (selected) on purpose: a
    // reset while the host holds cs low must not look like a fresh cs
    // fall, so framing only restarts after the host deselects and
    // reselects the device.
    // ------------------------------------------------------------------
    logic [SYNC_FF-1:0] r_sclk_sync;
    logic [SYNC_FF-1:0] r_cs_sync;
    logic [SYNC_FF-1:0] r_mosi_sync;
    logic [SYNC_FF-1:0] r_frame_sync;
    logic               r_sclk_prev;
    logic               r_cs_prev;

    logic w_sclk, w_cs, w_mosi, w_frame;
    assign w_sclk  = r_sclk_sync[SYNC_FF-1];
    assign w_cs    = r_cs_sync[SYNC_FF-1];
    assign w_mosi  = r_mosi_sync[SYNC_FF-1];
    assign w_frame = r_frame_sync[SYNC_FF-1];

    logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev;
    assign w_cs_fall   = r_cs_prev & ~w_cs;
    assign w_cs_rise   = ~r_cs_prev & w_cs;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               r_active;       // inside a valid cs-low window
    logic [c_CNT_W-1:0] r_bitcnt;
    logic [WORD_W-2:0]  r_rx_shift;     // first 31 bits of the current word
    logic [WORD_W-1:0]  r_tx;
    logic               r_tx_fresh;     // r_tx holds a new word, MSB not yet driven
    logic               r_miso;
    logic               r_f2h_tready;
    logic [WORD_W-1:0]  r_slot0;
    logic [WORD_W-1:0]  r_slot1;
    logic               r_wr_ptr;
    logic               r_rd_ptr;
    logic [1:0]         r_count;
    logic               r_h2f_ovf;
    logic               r_out_ovf;
    logic               r_int;

    // ------------------------------------------------------------------
    // Receive datapath decode
    // ------------------------------------------------------------------
    logic              w_shift;
    logic              w_word_done;
    logic [WORD_W-1:0] w_rx_word;
    logic              w_is_pkt;
    logic              w_clr;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;

    assign w_shift     = r_active & ~w_cs & w_sclk_rise;
    assign w_word_done = w_shift & (r_bitcnt == c_LAST_BIT);
    assign w_rx_word   = {r_rx_shift, w_mosi};
    assign w_is_pkt    = w_word_done & w_frame;
    assign w_clr       = w_word_done & ~w_frame & (w_rx_word[WORD_W-1 -: 8] == c_OP_CLR);

    // A word arriving while both slots are occupied is dropped, even if a
    // slot frees in the same cycle.
    assign w_pop  = (r_count != 2'd0) & h2f_tready;
    assign w_push = w_is_pkt & (r_count != 2'd2);
    assign w_drop = w_is_pkt & (r_count == 2'd2);

    // ------------------------------------------------------------------
    // Transmit word selection, evaluated at every word start
    // ------------------------------------------------------------------
    logic              w_load_tx;
    logic [WORD_W-1:0] w_status;
    logic [WORD_W-1:0] w_tx_next;

    assign w_load_tx = w_cs_fall | w_word_done;
    assign w_status  = {2'b10, r_out_ovf, r_h2f_ovf, fpga2host_fifo_filled,
                        host2fpga_fifo_empty, {(WORD_W-24){1'b0}}};
    assign w_tx_next = f2h_tvalid ? f2h_tdata : w_status;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync  <= '0;
            r_cs_sync    <= '0;
            r_mosi_sync  <= '0;
            r_frame_sync <= '0;
            r_sclk_prev  <= 1'b0;
            r_cs_prev    <= 1'b0;
            r_active     <= 1'b0;
            r_bitcnt     <= '0;
            r_rx_shift   <= '0;
            r_tx         <= '0;
            r_tx_fresh   <= 1'b0;
            r_miso       <= 1'b0;
            r_f2h_tready <= 1'b0;
            r_slot0      <= '0;
            r_slot1      <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_h2f_ovf    <= 1'b0;
            r_out_ovf    <= 1'b0;
            r_int        <= 1'b0;
        end else begin
            r_sclk_sync  <= {r_sclk_sync[SYNC_FF-2:0], spi_clk};
            r_cs_sync    <= {r_cs_sync[SYNC_FF-2:0], spi_cs};
            r_mosi_sync  <= {r_mosi_sync[SYNC_FF-2:0], spi_mosi};
            r_frame_sync <= {r_frame_sync[SYNC_FF-2:0], spi_frame};
            r_sclk_prev  <= w_sclk;
            r_cs_prev    <= w_cs;

            // Framing: a cs rise simply leaves the partial word behind;
            // the next cs fall restarts the bit counter.
            if (w_cs_fall) begin
                r_active <= 1'b1;
                r_bitcnt <= '0;
            end else if (w_cs_rise) begin
                r_active <= 1'b0;
            end else if (w_shift) begin
                r_rx_shift <= w_rx_word[WORD_W-2:0];
                r_bitcnt   <= w_word_done ? '0 : r_bitcnt + 1'b1;
            end

            // MISO: MSB is presented right at cs fall. At word completion
            // the next word is staged, and its MSB goes out on the
            // following falling edge instead of a shifted bit.
            if (w_cs_fall) begin
                r_tx       <= w_tx_next;
                r_miso     <= w_tx_next[WORD_W-1];
                r_tx_fresh <= 1'b0;
            end else if (!r_active || w_cs) begin
                r_miso     <= 1'b0;
            end else if (w_word_done) begin
                r_tx       <= w_tx_next;
                r_tx_fresh <= 1'b1;
            end else if (w_sclk_fall) begin
                if (r_tx_fresh) begin
                    r_miso     <= r_tx[WORD_W-1];
                    r_tx_fresh <= 1'b0;
                end else begin
                    r_miso <= r_tx[WORD_W-2];
                    r_tx   <= {r_tx[WORD_W-2:0], 1'b0};
                end
            end

            // The f2h word was captured this cycle; the source holds it
            // stable until the one-cycle ready pulse completes the beat.
            r_f2h_tready <= w_load_tx & f2h_tvalid;

            // Two-slot skid FIFO toward h2f
            if (w_push) begin
                if (r_wr_ptr) r_slot1 <= w_rx_word;
                else          r_slot0 <= w_rx_word;
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};

            // Sticky flags: a set in the same cycle as a clear wins.
            if (w_drop)                          r_h2f_ovf <= 1'b1;
            else if (w_clr)                      r_h2f_ovf <= 1'b0;
            if (err_outfifo_overflow_pulse)      r_out_ovf <= 1'b1;
            else if (w_clr)                      r_out_ovf <= 1'b0;

            r_int <= (fpga2host_fifo_filled != 10'd0) | r_out_ovf | r_h2f_ovf;
        end
    end

    assign spi_miso   = r_miso;
    assign f2h_tready = r_f2h_tready;
    assign h2f_tvalid = (r_count != 2'd0);
    assign h2f_tdata  = r_rd_ptr ? r_slot1 : r_slot0;
    assign spi_int    = r_int;

endmodule
`default_nettype wire

// File: tb/tb_spi_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_frontend
//  Description : Self-checking bench for spi_frontend. A table of words is
//                applied in one session, hand-written sequences cover
//                backpressure, read, status, flag and abort/reset cases, and
//                randomized sessions are compared against a transaction-level
//                model of the expected h2f words, MISO words and f2h pops.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_frontend;

    localparam int H = 4;   // SPI half period in clk cycles

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_clk, spi_cs, spi_mosi, spi_frame;
    logic        spi_miso;
    logic [31:0] h2f_tdata;
    logic        h2f_tvalid, h2f_tready;
    logic [31:0] f2h_tdata;
    logic        f2h_tvalid, f2h_tready;
    logic [9:0]  fpga2host_fifo_filled, host2fpga_fifo_empty;
    logic        err_outfifo_overflow_pulse;
    logic        spi_int;

    spi_frontend #(.WORD_W(32), .SYNC_FF(2)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .spi_clk                    (spi_clk),
        .spi_cs                     (spi_cs),
        .spi_mosi                   (spi_mosi),
        .spi_frame                  (spi_frame),
        .spi_miso                   (spi_miso),
        .h2f_tdata                  (h2f_tdata),
        .h2f_tvalid                 (h2f_tvalid),
        .h2f_tready                 (h2f_tready),
        .f2h_tdata                  (f2h_tdata),
        .f2h_tvalid                 (f2h_tvalid),
        .f2h_tready                 (f2h_tready),
        .fpga2host_fifo_filled      (fpga2host_fifo_filled),
        .host2fpga_fifo_empty       (host2fpga_fifo_empty),
        .err_outfifo_overflow_pulse (err_outfifo_overflow_pulse),
        .spi_int                    (spi_int)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] got_q[$];      // words accepted on h2f
    logic [31:0] f2h_q[$];      // words offered on f2h
    int          tready_cnt = 0;

    // Stream monitors: handshakes complete at posedge, so pre-update values
    // are read here.
    always @(posedge clk) begin
        if (h2f_tvalid && h2f_tready) got_q.push_back(h2f_tdata);
        if (f2h_tready) begin
            tready_cnt++;
            if (f2h_tvalid && f2h_q.size() > 0) f2h_q.delete(0);
        end
    end

    // f2h source: presents the queue head while anything is pending
    always @(negedge clk) begin
        f2h_tvalid = (f2h_q.size() != 0);
        f2h_tdata  = (f2h_q.size() != 0) ? f2h_q[0] : 32'h0;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] status(input logic oo, input logic ho,
                                           input logic [9:0] fl, input logic [9:0] em);
        return {2'b10, oo, ho, fl, em, 8'h00};
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        wait_clk(H);
    endtask

    task automatic cs_high();
        spi_cs = 1'b1;
        wait_clk(H);
    endtask

    // Mode 0 host: data set while clock low, sampled by both sides on rise.
    task automatic xfer(input logic [31:0] w, input logic f, input int nbits,
                        output logic [31:0] m);
        m = '0;
        spi_frame = f;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = w[31-i];
            wait_clk(H);
            m[31-i] = spi_miso;
            spi_clk = 1'b1;
            wait_clk(H);
            spi_clk = 1'b0;
        end
        wait_clk(H);
    endtask

    typedef struct {
        logic [31:0] data;
        logic        frame;
        logic        fwd;
    } vec_t;

    vec_t        tbl[7];
    logic [31:0] m;
    int          n0, c0;

    initial begin
        tbl[0] = '{32'h01000000, 1'b1, 1'b1};
        tbl[1] = '{32'h00000000, 1'b1, 1'b1};
        tbl[2] = '{32'h00000000, 1'b1, 1'b1};
        tbl[3] = '{32'hFFFFFFFF, 1'b1, 1'b1};
        tbl[4] = '{32'h00ABCDEF, 1'b0, 1'b0};   // NOP control
        tbl[5] = '{32'h02000000, 1'b0, 1'b0};   // unknown opcode
        tbl[6] = '{32'h80000001, 1'b1, 1'b1};

        rst = 1'b1;
        spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0; spi_frame = 1'b0;
        h2f_tready = 1'b0;
        fpga2host_fifo_filled = 10'd0;
        host2fpga_fifo_empty  = 10'd512;
        err_outfifo_overflow_pulse = 1'b0;
        wait_clk(5);
        chk("rst_miso",   {31'b0, spi_miso},   32'd0);
        chk("rst_tvalid", {31'b0, h2f_tvalid}, 32'd0);
        chk("rst_tready", {31'b0, f2h_tready}, 32'd0);
        chk("rst_int",    {31'b0, spi_int},    32'd0);
        rst = 1'b0;
        wait_clk(4);

        // ---------------- table: simple writes and control words ---------
        h2f_tready = 1'b1;
        cs_low();
        for (int i = 0; i < 7; i++) begin
            n0 = got_q.size();
            xfer(tbl[i].data, tbl[i].frame, 32, m);
            wait_clk(4);
            chk("tbl_count", got_q.size() - n0, tbl[i].fwd ? 1 : 0);
            if (tbl[i].fwd && got_q.size() > n0)
                chk("tbl_data", got_q[got_q.size()-1], tbl[i].data);
            chk("tbl_miso", m, status(1'b0, 1'b0, 10'd0, 10'd512));
        end
        cs_high();

        // ---------------- backpressure and h2f overflow ------------------
        h2f_tready = 1'b0;
        n0 = got_q.size();
        cs_low();
        xfer(32'hA5A5A5A5, 1'b1, 32, m);
        xfer(32'h5A5A5A5A, 1'b1, 32, m);
        xfer(32'h12345678, 1'b1, 32, m);
        cs_high();
        chk("bp_none_out", got_q.size() - n0, 0);
        chk("bp_tvalid",   {31'b0, h2f_tvalid}, 32'd1);
        chk("bp_head",     h2f_tdata, 32'hA5A5A5A5);
        chk("bp_int",      {31'b0, spi_int}, 32'd1);
        h2f_tready = 1'b1;
        wait_clk(4);
        chk("bp_drained", got_q.size() - n0, 2);
        if (got_q.size() >= n0 + 2) begin
            chk("bp_first",  got_q[n0],   32'hA5A5A5A5);
            chk("bp_second", got_q[n0+1], 32'h5A5A5A5A);
        end
        cs_low();
        xfer(32'h0, 1'b0, 32, m);
        cs_high();
        chk("bp_status", m, status(1'b0, 1'b1, 10'd0, 10'd512));
        n0 = got_q.size();
        cs_low();
        xfer(32'h01000000, 1'b0, 32, m);
        cs_high();
        wait_clk(3);
        chk("bp_clr_int", {31'b0, spi_int}, 32'd0);
        chk("bp_clr_noh2f", got_q.size() - n0, 0);

        // ---------------- out_ovf flag and clear -------------------------
        err_outfifo_overflow_pulse = 1'b1;
        wait_clk(1);
        err_outfifo_overflow_pulse = 1'b0;
        wait_clk(3);
        chk("ovf_int", {31'b0, spi_int}, 32'd1);
        cs_low();
        xfer(32'h0, 1'b0, 32, m);
        cs_high();
        chk("ovf_status", m, status(1'b1, 1'b0, 10'd0, 10'd512));
        n0 = got_q.size();
        cs_low();
        xfer(32'h01000000, 1'b0, 32, m);
        cs_high();
        wait_clk(3);
        chk("ovf_clr_int",   {31'b0, spi_int}, 32'd0);
        chk("ovf_clr_noh2f", got_q.size() - n0, 0);
        cs_low();
        xfer(32'h0, 1'b0, 32, m);
        cs_high();
        chk("ovf_clr_status", m, status(1'b0, 1'b0, 10'd0, 10'd512));

        // ---------------- read from f2h ----------------------------------
        f2h_q.push_back(32'hDEADBEEF);
        wait_clk(2);
        c0 = tready_cnt;
        cs_low();
        xfer(32'h0, 1'b0, 32, m);
        cs_high();
        chk("rd_data",   m, 32'hDEADBEEF);
        chk("rd_pulses", tready_cnt - c0, 1);
        chk("rd_popped", f2h_q.size(), 0);

        // ---------------- status word with counts ------------------------
        fpga2host_fifo_filled = 10'd3;
        host2fpga_fifo_empty  = 10'd512;
        wait_clk(3);
        chk("st_int", {31'b0, spi_int}, 32'd1);
        cs_low();
        xfer(32'h0, 1'b0, 32, m);
        cs_high();
        chk("st_word", m, status(1'b0, 1'b0, 10'd3, 10'd512));
        fpga2host_fifo_filled = 10'd0;
        wait_clk(3);

        // ---------------- abort after 17 bits ----------------------------
        n0 = got_q.size();
        cs_low();
        xfer(32'hCAFEF00D, 1'b1, 17, m);
        cs_high();
        chk("abort_none", got_q.size() - n0, 0);
        cs_low();
        xfer(32'h13579BDF, 1'b1, 32, m);
        cs_high();
        chk("abort_next_cnt", got_q.size() - n0, 1);
        if (got_q.size() > n0) chk("abort_next_data", got_q[n0], 32'h13579BDF);

        // ---------------- reset mid-transfer -----------------------------
        n0 = got_q.size();
        cs_low();
        xfer(32'hFFFF0000, 1'b1, 10, m);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        xfer(32'h0F0F0F0F, 1'b1, 32, m);
        chk("rstmid_none", got_q.size() - n0, 0);
        chk("rstmid_miso", {31'b0, spi_miso}, 32'd0);
        cs_high();
        cs_low();
        xfer(32'h2468ACE0, 1'b1, 32, m);
        cs_high();
        chk("rstmid_next_cnt", got_q.size() - n0, 1);
        if (got_q.size() > n0) chk("rstmid_next_data", got_q[n0], 32'h2468ACE0);

        // ---------------- randomized sessions vs. model ------------------
        for (int s = 0; s < 20; s++) begin
            logic [31:0] snap[$];
            int          nw, nf, used;
            logic [31:0] d, exp_m;
            logic        f;
            fpga2host_fifo_filled = ($urandom_range(0, 1) == 0) ? 10'd0
                                    : 10'($urandom_range(1, 512));
            host2fpga_fifo_empty  = 10'($urandom_range(0, 512));
            nf = $urandom_range(0, 3);
            for (int k = 0; k < nf; k++) f2h_q.push_back($urandom);
            wait_clk(3);
            snap = f2h_q;
            nw   = $urandom_range(1, 3);
            cs_low();
            for (int k = 0; k < nw; k++) begin
                d = $urandom;
                f = 1'($urandom_range(0, 1));
                exp_m = (k < snap.size()) ? snap[k]
                        : status(1'b0, 1'b0, fpga2host_fifo_filled, host2fpga_fifo_empty);
                n0 = got_q.size();
                xfer(d, f, 32, m);
                wait_clk(4);
                chk("rnd_miso", m, exp_m);
                chk("rnd_count", got_q.size() - n0, f ? 1 : 0);
                if (f && got_q.size() > n0) chk("rnd_data", got_q[n0], d);
            end
            cs_high();
            // one selection per word start plus one at the final completion
            used = (snap.size() < nw + 1) ? snap.size() : nw + 1;
            chk("rnd_f2h_left", f2h_q.size(), snap.size() - used);
            chk("rnd_int", {31'b0, spi_int}, {31'b0, fpga2host_fifo_filled != 10'd0});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
